// File: rtl/fifo.sv
// First-word-fall-through circular-buffer FIFO with registered status, sticky
// overflow/underflow flags and programmable almost-full/almost-empty levels.
module fifo #(
   parameter int unsigned ADDR_WIDTH       = 4,
   parameter int unsigned DATA_WIDTH       = 4,
   parameter int unsigned ALMOST_FULL_LVL  = 14,
   parameter int unsigned ALMOST_EMPTY_LVL = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  write_i,
   input  logic [DATA_WIDTH-1:0] write_data_i,
   input  logic                  read_i,
   input  logic                  clear_flags_i,
   output logic [DATA_WIDTH-1:0] read_data_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  almost_empty_o,
   output logic                  almost_full_o,
   output logic [ADDR_WIDTH:0]   count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] wr_ptr_nxt;
   logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
   logic [CNT_W-1:0]      count_nxt;
   logic [DATA_WIDTH-1:0] head_nxt;
   logic                  wr_accept;
   logic                  rd_accept;
   logic                  overflow_nxt;
   logic                  underflow_nxt;

   // Accept decisions, next pointers and next count.
   always_comb begin
      rd_accept  = read_i && !empty_o;
      wr_accept  = write_i && (!full_o || read_i);
      wr_ptr_nxt = wr_accept ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
      rd_ptr_nxt = rd_accept ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
      count_nxt  = count_o;
      case ({wr_accept, rd_accept})
         2'b10:   count_nxt = count_o + CNT_W'(1);
         2'b01:   count_nxt = count_o - CNT_W'(1);
         default: count_nxt = count_o;
      endcase
   end

   // Next head word; bypass the incoming word when it lands on the new head slot.
   always_comb begin
      head_nxt = '0;
      if (count_nxt != '0) begin
         if (wr_accept && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = write_data_i;
         end else begin
            head_nxt = mem[rd_ptr_nxt];
         end
      end
   end

   // Sticky error flags: a new event wins over a coincident clear.
   always_comb begin
      overflow_nxt  = overflow_o;
      underflow_nxt = underflow_o;
      if (clear_flags_i) begin
         overflow_nxt  = 1'b0;
         underflow_nxt = 1'b0;
      end
      if (write_i && full_o && !read_i) begin
         overflow_nxt = 1'b1;
      end
      if (read_i && empty_o) begin
         underflow_nxt = 1'b1;
      end
   end

   // Storage array is deliberately left uncleared by reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i && wr_accept) begin
         mem[wr_ptr] <= write_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count_o        <= '0;
         read_data_o    <= '0;
         empty_o        <= 1'b1;
         full_o         <= 1'b0;
         almost_empty_o <= 1'b1;
         almost_full_o  <= 1'b0;
         overflow_o     <= 1'b0;
         underflow_o    <= 1'b0;
      end else begin
         wr_ptr         <= wr_ptr_nxt;
         rd_ptr         <= rd_ptr_nxt;
         count_o        <= count_nxt;
         read_data_o    <= head_nxt;
         empty_o        <= (count_nxt == '0);
         full_o         <= (count_nxt == CNT_W'(DEPTH));
         almost_empty_o <= (count_nxt <= CNT_W'(ALMOST_EMPTY_LVL));
         almost_full_o  <= (count_nxt >= CNT_W'(ALMOST_FULL_LVL));
         overflow_o     <= overflow_nxt;
         underflow_o    <= underflow_nxt;
      end
   end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for the FWFT fifo: reset, fill/drain, overflow, simultaneous
// access at full/empty, pointer wrap with thresholds, and mid-operation reset.
module tb_fifo;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b0;
   logic       write_i = 1'b0;
   logic [3:0] write_data_i = '0;
   logic       read_i = 1'b0;
   logic       clear_flags_i = 1'b0;
   logic [3:0] read_data_o;
   logic       empty_o;
   logic       full_o;
   logic       almost_empty_o;
   logic       almost_full_o;
   logic [4:0] count_o;
   logic       overflow_o;
   logic       underflow_o;

   int checks = 0;
   int failures = 0;

   fifo dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .write_i        (write_i),
      .write_data_i   (write_data_i),
      .read_i         (read_i),
      .clear_flags_i  (clear_flags_i),
      .read_data_o    (read_data_o),
      .empty_o        (empty_o),
      .full_o         (full_o),
      .almost_empty_o (almost_empty_o),
      .almost_full_o  (almost_full_o),
      .count_o        (count_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic rst, input logic w, input logic [3:0] d,
                       input logic r, input logic c);
      reset_i       = rst;
      write_i       = w;
      write_data_i  = d;
      read_i        = r;
      clear_flags_i = c;
      @(posedge clk_i);
      #1;
      reset_i       = 1'b0;
      write_i       = 1'b0;
      write_data_i  = 4'hf;
      read_i        = 1'b0;
      clear_flags_i = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_v;
      #2;

      // Reset
      step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      check("rst_empty", 32'(empty_o), 32'd1);
      check("rst_full", 32'(full_o), 32'd0);
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_rdata", 32'(read_data_o), 32'd0);
      check("rst_ovf", 32'(overflow_o), 32'd0);
      check("rst_unf", 32'(underflow_o), 32'd0);
      check("rst_aempty", 32'(almost_empty_o), 32'd1);
      check("rst_afull", 32'(almost_full_o), 32'd0);

      // write_data_i ignored without write_i
      step(1'b0, 1'b0, 4'h9, 1'b0, 1'b0);
      check("idle_count", 32'(count_o), 32'd0);

      // Fill with 1..16 (16 truncates to 0 in 4 bits)
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
         check("fill_count", 32'(count_o), 32'(i));
         check("fill_head", 32'(read_data_o), 32'd1);
         check("fill_afull", 32'(almost_full_o), 32'(i >= 14));
         check("fill_aempty", 32'(almost_empty_o), 32'(i <= 2));
         check("fill_full", 32'(full_o), 32'(i == 16));
      end

      // Overflow: dropped write, then clear, then set-wins-over-clear
      step(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      check("ovf_count", 32'(count_o), 32'd16);
      check("ovf_flag", 32'(overflow_o), 32'd1);
      check("ovf_head", 32'(read_data_o), 32'd1);
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      check("ovf_clear", 32'(overflow_o), 32'd0);
      step(1'b0, 1'b1, 4'h5, 1'b0, 1'b1);
      check("ovf_set_wins", 32'(overflow_o), 32'd1);
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      check("ovf_clear2", 32'(overflow_o), 32'd0);

      // Simultaneous read+write at full
      step(1'b0, 1'b1, 4'h9, 1'b1, 1'b0);
      check("full_rw_count", 32'(count_o), 32'd16);
      check("full_rw_head", 32'(read_data_o), 32'd2);
      check("full_rw_ovf", 32'(overflow_o), 32'd0);

      // Drain: 2..15, 0, 9
      for (int i = 2; i <= 17; i++) begin
         exp_v = (i == 17) ? 4'd9 : 4'(i);
         check("drain1_data", 32'(read_data_o), 32'(exp_v));
         step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      end
      check("drain1_empty", 32'(empty_o), 32'd1);
      check("drain1_count", 32'(count_o), 32'd0);
      check("drain1_rdata", 32'(read_data_o), 32'd0);
      check("drain1_unf", 32'(underflow_o), 32'd0);

      // Simultaneous read+write at empty
      step(1'b0, 1'b1, 4'h7, 1'b1, 1'b0);
      check("empty_rw_count", 32'(count_o), 32'd1);
      check("empty_rw_head", 32'(read_data_o), 32'd7);
      check("empty_rw_unf", 32'(underflow_o), 32'd1);
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
      check("unf_clear", 32'(underflow_o), 32'd0);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      check("empty_again", 32'(empty_o), 32'd1);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      check("unf_set_wins", 32'(underflow_o), 32'd1);
      step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

      // Wrap: write 10, read 10, then fill 0..15
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'(i + 3), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("wrap_pre_data", 32'(read_data_o), 32'(i + 3));
         step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
         check("wrap_afull", 32'(almost_full_o), 32'(i + 1 >= 14));
         check("wrap_aempty", 32'(almost_empty_o), 32'(i + 1 <= 2));
      end
      check("wrap_full", 32'(full_o), 32'd1);
      for (int i = 0; i < 16; i++) begin
         check("wrap_data", 32'(read_data_o), 32'(i));
         step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
         check("wrap_count", 32'(count_o), 32'(15 - i));
      end
      check("wrap_empty", 32'(empty_o), 32'd1);

      // Reset mid-operation
      for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 4'(i + 8), 1'b0, 1'b0);
      check("mid_count6", 32'(count_o), 32'd6);
      step(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
      check("mid_rst_count", 32'(count_o), 32'd0);
      check("mid_rst_empty", 32'(empty_o), 32'd1);
      check("mid_rst_rdata", 32'(read_data_o), 32'd0);
      step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
      check("mid_post_data", 32'(read_data_o), 32'd3);
      check("mid_post_count", 32'(count_o), 32'd1);
      step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      check("mid_post_empty", 32'(empty_o), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
